// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order prediction queue checked against execute outcomes.
// Define BRU_STATS_EN to build the branch/mispredict statistic counters.
module branch_resolve_unit #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Pred_valid,
  input  logic        Pred_taken,
  input  logic [31:0] Pred_addr,
  output logic        Pred_ready,
  input  logic        Res_valid,
  input  logic        Res_taken,
  input  logic [31:0] Res_addr,
  input  logic [31:0] Res_target,
  output logic        Mispredict,
  output logic [31:0] Redirect_addr,
  output logic        Flush,
  output logic        Res_error,
  output logic [31:0] Branch_count,
  output logic [31:0] Mispredict_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [DEPTH-1:0] q_taken;
  logic [31:0]      q_addr [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [FW-1:0]    flush_cnt;

  logic        is_idle, empty, push, pop;
  logic        res_evt, addr_hit, mis_evt, err_evt;
  logic        head_taken;
  logic [31:0] head_addr;

  // Resolution sees the head as it stood at the start of the cycle.
  always_comb begin
    head_taken = q_taken[rd_ptr];
    head_addr  = q_addr[rd_ptr];
    is_idle    = (state == IDLE);
    empty      = (count == '0);
    push       = Pred_valid && Pred_ready;
    res_evt    = is_idle && Res_valid;
    addr_hit   = (head_addr == Res_addr);
    err_evt    = res_evt && (empty || !addr_hit);
    mis_evt    = res_evt && !empty
                 && (!addr_hit || (head_taken != Res_taken));
    pop        = res_evt && !empty && addr_hit
                 && (head_taken == Res_taken);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (mis_evt) state_nxt = FLUSH;
      FLUSH: if (flush_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Flush      = (state == FLUSH);
    Pred_ready = is_idle && (count < CW'(DEPTH));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      flush_cnt <= '0;
    end else if (mis_evt) begin
      flush_cnt <= FW'(FLUSH_CYCLES - 1);
    end else if (state == FLUSH && flush_cnt != '0) begin
      flush_cnt <= flush_cnt - 1'b1;
    end
  end

  // A mispredict squashes every entry, including a same-cycle push.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (mis_evt) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      q_taken[wr_ptr] <= Pred_taken;
      q_addr[wr_ptr]  <= Pred_addr;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Mispredict    <= 1'b0;
      Res_error     <= 1'b0;
      Redirect_addr <= '0;
    end else begin
      Mispredict <= mis_evt;
      Res_error  <= err_evt;
      if (mis_evt)
        Redirect_addr <= Res_taken ? Res_target
                                   : Res_addr + 32'd4;
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Branch_count     <= '0;
      Mispredict_count <= '0;
    end else begin
      if ((pop || mis_evt) && Branch_count != '1)
        Branch_count <= Branch_count + 1'b1;
      if (mis_evt && Mispredict_count != '1)
        Mispredict_count <= Mispredict_count + 1'b1;
    end
  end
`else
  assign Branch_count     = '0;
  assign Mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit (DEPTH=4, FLUSH_CYCLES=2).
// Counter expectations follow whether BRU_STATS_EN is defined.
module tb_branch_resolve_unit;

`ifdef BRU_STATS_EN
  localparam bit ST = 1'b1;
`else
  localparam bit ST = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Pred_valid, Pred_taken;
  logic [31:0] Pred_addr;
  logic        Pred_ready;
  logic        Res_valid, Res_taken;
  logic [31:0] Res_addr, Res_target;
  logic        Mispredict, Flush, Res_error;
  logic [31:0] Redirect_addr, Branch_count, Mispredict_count;

  int ncmp = 0;
  int nerr = 0;
  logic [31:0] eb = 0;
  logic [31:0] em = 0;

  always #5 CLK = ~CLK;

  branch_resolve_unit #(.DEPTH(4), .FLUSH_CYCLES(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .Pred_valid(Pred_valid), .Pred_taken(Pred_taken),
    .Pred_addr(Pred_addr), .Pred_ready(Pred_ready),
    .Res_valid(Res_valid), .Res_taken(Res_taken),
    .Res_addr(Res_addr), .Res_target(Res_target),
    .Mispredict(Mispredict), .Redirect_addr(Redirect_addr),
    .Flush(Flush), .Res_error(Res_error),
    .Branch_count(Branch_count),
    .Mispredict_count(Mispredict_count)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic t, input logic [31:0] a);
    Pred_valid = 1'b1; Pred_taken = t; Pred_addr = a;
    tick();
    Pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic t, input logic [31:0] a,
                         input logic [31:0] tg);
    Res_valid = 1'b1; Res_taken = t; Res_addr = a; Res_target = tg;
    tick();
    Res_valid = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    Pred_valid = 0; Pred_taken = 0; Pred_addr = 0;
    Res_valid = 0; Res_taken = 0; Res_addr = 0; Res_target = 0;
    tick(); tick();
    RESET = 1'b0;
    tick();
    ncmp++;
    if (Pred_ready !== 1'b1 || Flush !== 1'b0 || Mispredict !== 1'b0
        || Res_error !== 1'b0) begin
      nerr++;
      $display("FAIL reset_ctl: rdy=%b fl=%b mp=%b er=%b want 1 0 0 0",
               Pred_ready, Flush, Mispredict, Res_error);
    end
    ncmp++;
    if (Redirect_addr !== 32'd0 || Branch_count !== 32'd0
        || Mispredict_count !== 32'd0) begin
      nerr++;
      $display("FAIL reset_val: redir=%h bc=%0d mc=%0d want 0 0 0",
               Redirect_addr, Branch_count, Mispredict_count);
    end
  endtask

  task automatic test_correct();
    push(1'b0, 32'h100);
    resolve(1'b0, 32'h100, 32'h0);
    eb++;
    ncmp++;
    if (Mispredict !== 1'b0 || Res_error !== 1'b0 || Flush !== 1'b0) begin
      nerr++;
      $display("FAIL correct_ctl: mp=%b er=%b fl=%b want 0 0 0",
               Mispredict, Res_error, Flush);
    end
    ncmp++;
    if (Branch_count !== (ST ? eb : 32'd0)
        || Mispredict_count !== (ST ? em : 32'd0)) begin
      nerr++;
      $display("FAIL correct_cnt: bc=%0d mc=%0d want %0d %0d",
               Branch_count, Mispredict_count,
               ST ? eb : 32'd0, ST ? em : 32'd0);
    end
  endtask

  task automatic test_mispredict();
    push(1'b0, 32'h200);
    resolve(1'b1, 32'h200, 32'h400);
    eb++; em++;
    ncmp++;
    if (Mispredict !== 1'b1 || Redirect_addr !== 32'h400) begin
      nerr++;
      $display("FAIL mp_pulse: mp=%b redir=%h want 1 400",
               Mispredict, Redirect_addr);
    end
    ncmp++;
    if (Flush !== 1'b1 || Pred_ready !== 1'b0 || Res_error !== 1'b0) begin
      nerr++;
      $display("FAIL mp_flush1: fl=%b rdy=%b er=%b want 1 0 0",
               Flush, Pred_ready, Res_error);
    end
    ncmp++;
    if (Branch_count !== (ST ? eb : 32'd0)
        || Mispredict_count !== (ST ? em : 32'd0)) begin
      nerr++;
      $display("FAIL mp_cnt: bc=%0d mc=%0d want %0d %0d",
               Branch_count, Mispredict_count,
               ST ? eb : 32'd0, ST ? em : 32'd0);
    end
    tick();
    ncmp++;
    if (Mispredict !== 1'b0 || Flush !== 1'b1 || Pred_ready !== 1'b0) begin
      nerr++;
      $display("FAIL mp_flush2: mp=%b fl=%b rdy=%b want 0 1 0",
               Mispredict, Flush, Pred_ready);
    end
    tick();
    ncmp++;
    if (Flush !== 1'b0 || Pred_ready !== 1'b1
        || Redirect_addr !== 32'h400) begin
      nerr++;
      $display("FAIL mp_done: fl=%b rdy=%b redir=%h want 0 1 400",
               Flush, Pred_ready, Redirect_addr);
    end
  endtask

  task automatic test_flush_queue();
    push(1'b1, 32'h300);
    push(1'b0, 32'h304);
    push(1'b0, 32'h308);
    resolve(1'b0, 32'h300, 32'hDEAD_0000);
    eb++; em++;
    ncmp++;
    if (Mispredict !== 1'b1 || Redirect_addr !== 32'h304) begin
      nerr++;
      $display("FAIL fq_redir: mp=%b redir=%h want 1 304",
               Mispredict, Redirect_addr);
    end
    push(1'b0, 32'h600);
    tick();
    resolve(1'b0, 32'h600, 32'h0);
    ncmp++;
    if (Res_error !== 1'b1 || Mispredict !== 1'b0) begin
      nerr++;
      $display("FAIL fq_dropped: er=%b mp=%b want 1 0",
               Res_error, Mispredict);
    end
    tick();
    ncmp++;
    if (Res_error !== 1'b0 || Branch_count !== (ST ? eb : 32'd0)
        || Mispredict_count !== (ST ? em : 32'd0)) begin
      nerr++;
      $display("FAIL fq_after: er=%b bc=%0d mc=%0d want 0 %0d %0d",
               Res_error, Branch_count, Mispredict_count,
               ST ? eb : 32'd0, ST ? em : 32'd0);
    end
  endtask

  task automatic test_full();
    logic [31:0] addrs [4];
    addrs[0] = 32'h10; addrs[1] = 32'h14;
    addrs[2] = 32'h18; addrs[3] = 32'h1C;
    for (int i = 0; i < 4; i++) push(1'b0, addrs[i]);
    ncmp++;
    if (Pred_ready !== 1'b0) begin
      nerr++;
      $display("FAIL full_ready: got %b want 0", Pred_ready);
    end
    Pred_valid = 1'b1; Pred_taken = 1'b0; Pred_addr = 32'h20;
    Res_valid = 1'b1; Res_taken = 1'b0; Res_addr = 32'h10;
    tick();
    Pred_valid = 1'b0; Res_valid = 1'b0;
    eb++;
    ncmp++;
    if (Pred_ready !== 1'b1 || Mispredict !== 1'b0 || Res_error !== 1'b0) begin
      nerr++;
      $display("FAIL full_pushpop: rdy=%b mp=%b er=%b want 1 0 0",
               Pred_ready, Mispredict, Res_error);
    end
    for (int i = 1; i < 4; i++) begin
      resolve(1'b0, addrs[i], 32'h0);
      eb++;
      ncmp++;
      if (Mispredict !== 1'b0 || Res_error !== 1'b0) begin
        nerr++;
        $display("FAIL full_drain%0d: mp=%b er=%b want 0 0",
                 i, Mispredict, Res_error);
      end
    end
    resolve(1'b0, 32'h20, 32'h0);
    ncmp++;
    if (Res_error !== 1'b1 || Branch_count !== (ST ? eb : 32'd0)) begin
      nerr++;
      $display("FAIL full_refused: er=%b bc=%0d want 1 %0d",
               Res_error, Branch_count, ST ? eb : 32'd0);
    end
  endtask

  task automatic test_empty_push();
    Pred_valid = 1'b1; Pred_taken = 1'b0; Pred_addr = 32'h500;
    Res_valid = 1'b1; Res_taken = 1'b0; Res_addr = 32'h500;
    tick();
    Pred_valid = 1'b0; Res_valid = 1'b0;
    ncmp++;
    if (Res_error !== 1'b1 || Mispredict !== 1'b0 || Flush !== 1'b0) begin
      nerr++;
      $display("FAIL empty_err: er=%b mp=%b fl=%b want 1 0 0",
               Res_error, Mispredict, Flush);
    end
    ncmp++;
    if (Branch_count !== (ST ? eb : 32'd0)
        || Mispredict_count !== (ST ? em : 32'd0)) begin
      nerr++;
      $display("FAIL empty_cnt: bc=%0d mc=%0d want %0d %0d",
               Branch_count, Mispredict_count,
               ST ? eb : 32'd0, ST ? em : 32'd0);
    end
    resolve(1'b0, 32'h500, 32'h0);
    eb++;
    ncmp++;
    if (Res_error !== 1'b0 || Mispredict !== 1'b0
        || Branch_count !== (ST ? eb : 32'd0)) begin
      nerr++;
      $display("FAIL empty_held: er=%b mp=%b bc=%0d want 0 0 %0d",
               Res_error, Mispredict, Branch_count, ST ? eb : 32'd0);
    end
  endtask

  task automatic test_addr_mismatch();
    push(1'b0, 32'h700);
    resolve(1'b0, 32'h704, 32'h0);
    eb++; em++;
    ncmp++;
    if (Mispredict !== 1'b1 || Res_error !== 1'b1
        || Redirect_addr !== 32'h708 || Flush !== 1'b1) begin
      nerr++;
      $display("FAIL mismatch: mp=%b er=%b redir=%h fl=%b want 1 1 708 1",
               Mispredict, Res_error, Redirect_addr, Flush);
    end
    ncmp++;
    if (Mispredict_count !== (ST ? em : 32'd0)) begin
      nerr++;
      $display("FAIL mismatch_cnt: mc=%0d want %0d",
               Mispredict_count, ST ? em : 32'd0);
    end
    tick(); tick();
    ncmp++;
    if (Flush !== 1'b0 || Pred_ready !== 1'b1) begin
      nerr++;
      $display("FAIL mismatch_end: fl=%b rdy=%b want 0 1", Flush, Pred_ready);
    end
  endtask

  task automatic test_reset_mid_flush();
    push(1'b0, 32'h800);
    resolve(1'b1, 32'h800, 32'h900);
    ncmp++;
    if (Mispredict !== 1'b1 || Redirect_addr !== 32'h900) begin
      nerr++;
      $display("FAIL rmf_pre: mp=%b redir=%h want 1 900",
               Mispredict, Redirect_addr);
    end
    tick();
    ncmp++;
    if (Flush !== 1'b1) begin
      nerr++;
      $display("FAIL rmf_flush2: fl=%b want 1", Flush);
    end
    RESET = 1'b1;
    #1;
    ncmp++;
    if (Flush !== 1'b0 || Mispredict !== 1'b0 || Redirect_addr !== 32'd0
        || Pred_ready !== 1'b1) begin
      nerr++;
      $display("FAIL rmf_reset: fl=%b mp=%b redir=%h rdy=%b want 0 0 0 1",
               Flush, Mispredict, Redirect_addr, Pred_ready);
    end
    ncmp++;
    if (Branch_count !== 32'd0 || Mispredict_count !== 32'd0) begin
      nerr++;
      $display("FAIL rmf_cnt: bc=%0d mc=%0d want 0 0",
               Branch_count, Mispredict_count);
    end
    #2;
    RESET = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_correct();
    test_mispredict();
    test_flush_queue();
    test_full();
    test_empty_push();
    test_addr_mismatch();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer end of the branch-prediction path: fetch pushes each predicted branch (PC, predicted direction); execute later reports the actual outcome.
- Holds in-flight predictions in order and compares each resolution against the oldest entry.
- On a mispredict: raises a one-cycle Mispredict, drives Redirect_addr and holds Flush for a fixed number of cycles.
- Optionally keeps branch and mispredict statistics.

Parameters:
- DEPTH, 4, maximum in-flight unresolved branches; power of 2, at least 2.
- FLUSH_CYCLES, 2, cycles Flush stays asserted after a mispredict; at least 1.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- Pred_valid  input  1  fetch presents a predicted branch this cycle.
- Pred_taken  input  1  predicted direction (1 = taken).
- Pred_addr  input  32  PC of the predicted branch.
- Pred_ready  output  1  queue can accept a push this cycle.
- Res_valid  input  1  execute reports a resolved branch this cycle.
- Res_taken  input  1  actual direction.
- Res_addr  input  32  PC of the resolved branch.
- Res_target  input  32  actual taken target.
- Mispredict  output  1  one-cycle pulse on a mispredict.
- Redirect_addr  output  32  corrected fetch address.
- Flush  output  1  squash the wrong path.
- Res_error  output  1  one-cycle pulse on an unmatched resolution.
- Branch_count  output  32  resolutions processed.
- Mispredict_count  output  32  mispredicts detected.

Behaviour:
- Reset values:
  - state IDLE, queue empty, Pred_ready=1.
  - Mispredict, Flush, Res_error = 0.
  - Redirect_addr, Branch_count, Mispredict_count = 0.
- Queue: DEPTH-entry FIFO of {taken, addr}, read/write pointers plus an occupancy count.
  - Pred_ready = (state==IDLE) && (count<DEPTH); registered-state combinational.
  - Push occurs when Pred_valid && Pred_ready.
- Resolution (IDLE only): evaluated on Res_valid against the head entry as it was at the start of the cycle. A push in the same cycle never satisfies that resolution.
  - Queue empty: Res_error=1 next cycle. No pop, no counter change, no flush.
  - Head addr != Res_addr: treated as a mispredict and Res_error=1 next cycle.
  - Head taken == Res_taken and addrs match: pop head, Branch_count+1, no other output.
  - Head taken != Res_taken, addrs match: mispredict.
- Mispredict handling, all outputs registered (visible the cycle after Res_valid):
  - Mispredict=1 for exactly one cycle.
  - Redirect_addr = Res_taken ? Res_target : Res_addr+4, modulo 2^32. It holds until the next mispredict.
  - Branch_count+1 and Mispredict_count+1.
  - Entire queue cleared, including any same-cycle push; younger entries are wrong-path.
  - State moves to FLUSH.
- State FLUSH:
  - Flush=1 for FLUSH_CYCLES cycles, beginning the same cycle as Mispredict.
  - Pred_ready=0; Pred_valid and Res_valid are ignored (no error, no count).
  - After the last flush cycle, return to IDLE with Flush=0 and Pred_ready=1.
- Push and pop in the same cycle:
  - Allowed when not full; count unchanged.
  - When full, Pred_ready=0, so the push is refused even if a pop occurs.
- Counters saturate at 32'hFFFFFFFF; no wrap.
- RESET mid-FLUSH or with queue occupied returns immediately to reset values.

Optional Feature:
- Macro BRU_STATS_EN.
- Defined: Branch_count and Mispredict_count implemented as above.
- Undefined: both outputs constant 0 and no counter registers are built. All other behaviour is identical.

Test Plan:
- Reset, then push {taken=0, 0x100}, resolve {taken=0, addr 0x100}: no Mispredict, queue empty, Branch_count=1, Mispredict_count=0.
- Push {0, 0x200}, resolve {taken=1, addr 0x200, target 0x400}:
  - next cycle Mispredict=1 for 1 cycle and Redirect_addr=0x400;
  - Flush=1 for 2 cycles and Pred_ready=0 for those cycles;
  - Mispredict_count=1.
- Push {1, 0x300}, {0, 0x304}, {0, 0x308}, then resolve 0x300 with taken=0:
  - Redirect_addr=0x304 and queue emptied;
  - a push attempted during Flush is dropped.
- Push 4 entries (DEPTH=4): Pred_ready=0. Push and resolve-head in the same cycle: push refused, count becomes 3, Pred_ready=1.
- Res_valid with empty queue (same-cycle push of 0x500): Res_error=1 for 1 cycle, count=1 afterwards, counters unchanged.
- Assert RESET during the second Flush cycle: Flush, Mispredict and Redirect_addr go to 0 immediately and Pred_ready=1. With BRU_STATS_EN undefined, counters read 0 throughout.
